// File: rtl/hack_program_counter.sv
// Hack CPU program counter with a hardware return-address stack.
// Supports clear, jump (load), increment and hold, plus call/ret linkage
// through a small LIFO so subroutine return addresses never touch RAM.
// Overflow/underflow are sticky and only cleared by clr or reset_n.
module hack_program_counter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       clr,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_out;
    logic [DW-1:0]    r_depth;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_out_inc;
    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_pop_data;

    logic [WIDTH-1:0] w_out_nxt;
    logic [DW-1:0]    w_depth_nxt;
    logic             w_overflow_nxt;
    logic             w_underflow_nxt;
    logic             w_push;

    // Return address wraps modulo 2^WIDTH, same as a plain increment.
    assign w_out_inc  = r_out + WIDTH'(1);
    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_empty    = (r_depth == '0);
    // depth is at most DEPTH, so its low AW bits address the stack directly;
    // when full they wrap to 0 and depth-1 wraps back to DEPTH-1.
    assign w_push_idx = r_depth[AW-1:0];
    assign w_top_idx  = r_depth[AW-1:0] - AW'(1);
    assign w_pop_data = r_stack[w_top_idx];

    // Next-state selection: clr > call > ret > load > inc > hold.
    always_comb begin
        w_out_nxt       = r_out;
        w_depth_nxt     = r_depth;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_push          = 1'b0;
        if (clr) begin
            w_out_nxt       = '0;
            w_depth_nxt     = '0;
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end else if (call) begin
            // The jump always happens; only the push is lost when full.
            w_out_nxt = in;
            if (w_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_push      = 1'b1;
                w_depth_nxt = r_depth + DW'(1);
            end
        end else if (ret) begin
            if (w_empty) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_out_nxt   = w_pop_data;
                w_depth_nxt = r_depth - DW'(1);
            end
        end else if (load) begin
            w_out_nxt = in;
        end else if (inc) begin
            w_out_nxt = w_out_inc;
        end
    end

    // Architectural state register; synchronous reset overrides everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_depth     <= w_depth_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Stack storage needs no reset: entries at or above depth are never read.
    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            r_stack[w_push_idx] <= w_out_inc;
        end
    end

    assign out       = r_out;
    assign depth     = r_depth;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_hack_program_counter.sv
// Directed test of hack_program_counter: stimulus pushes expected state into
// a queue, a negedge monitor pops and compares against the DUT outputs.
module tb_hack_program_counter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] in;
    logic             load, inc, clr, call, ret;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             overflow, underflow;

    typedef struct {
        logic [WIDTH-1:0] e_out;
        logic [DW-1:0]    e_depth;
        logic             e_ov;
        logic             e_un;
        string            name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hack_program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .inc      (inc),
        .clr      (clr),
        .call     (call),
        .ret      (ret),
        .out      (out),
        .depth    (depth),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: registered outputs are checked at the negedge after each edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (out !== e.e_out || depth !== e.e_depth ||
                    overflow !== e.e_ov || underflow !== e.e_un) begin
                    n_bad++;
                    $display("FAIL %s: got out=%h depth=%0d ov=%b un=%b, want out=%h depth=%0d ov=%b un=%b",
                             e.name, out, depth, overflow, underflow,
                             e.e_out, e.e_depth, e.e_ov, e.e_un);
                end
            end
        end
    end

    // Apply one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic rn, input logic c_clr, input logic c_call,
                        input logic c_ret, input logic c_load, input logic c_inc,
                        input logic [WIDTH-1:0] c_in,
                        input logic [WIDTH-1:0] x_out, input int x_depth,
                        input logic x_ov, input logic x_un, input string nm);
        exp_t e;
        reset_n = rn; clr = c_clr; call = c_call; ret = c_ret;
        load = c_load; inc = c_inc; in = c_in;
        e.e_out = x_out; e.e_depth = DW'(x_depth);
        e.e_ov = x_ov; e.e_un = x_un; e.name = nm;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] rv;

    initial begin
        reset_n = 1'b1; clr = 0; call = 0; ret = 0; load = 0; inc = 0; in = '0;

        // 1: reset then increment
        step(0,0,0,0,0,0,16'h0000, 16'h0000,0,0,0, "reset");
        step(1,0,0,0,0,1,16'h0000, 16'h0001,0,0,0, "inc1");
        step(1,0,0,0,0,1,16'h0000, 16'h0002,0,0,0, "inc2");
        step(1,0,0,0,0,1,16'h0000, 16'h0003,0,0,0, "inc3");
        step(1,0,0,0,0,0,16'h1234, 16'h0003,0,0,0, "hold");

        // 2: load, and load beats inc
        step(1,0,0,0,0,1,16'h0000, 16'h0004,0,0,0, "inc4");
        step(1,0,0,0,0,1,16'h0000, 16'h0005,0,0,0, "inc5");
        step(1,0,0,0,1,0,16'h0100, 16'h0100,0,0,0, "load");
        step(1,0,0,0,1,1,16'h0200, 16'h0200,0,0,0, "load_over_inc");

        // 3: call / inc / ret
        step(1,0,0,0,1,0,16'h0010, 16'h0010,0,0,0, "load10");
        step(1,0,1,0,0,0,16'h0400, 16'h0400,1,0,0, "call");
        step(1,0,0,0,0,1,16'h0000, 16'h0401,1,0,0, "sub_inc1");
        step(1,0,0,0,0,1,16'h0000, 16'h0402,1,0,0, "sub_inc2");
        step(1,0,0,1,0,0,16'h0000, 16'h0011,0,0,0, "ret");

        // 4: fill stack, overflow, drain, underflow (out=0x0011 here)
        for (int k = 0; k < DEPTH; k++) begin
            tgt = 16'h1000 + 16'(k * 16);
            step(1,0,1,0,0,0,tgt, tgt,k+1,0,0, "fill_call");
        end
        step(1,0,1,0,0,0,16'h0999, 16'h0999,DEPTH,1,0, "overflow_call");
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rv = (k == 0) ? 16'h0012 : 16'h1000 + 16'((k - 1) * 16) + 16'h0001;
            step(1,0,0,1,0,0,16'h0000, rv,k,1,0, "drain_ret");
        end
        step(1,0,0,1,0,0,16'h0000, 16'h0012,0,1,1, "underflow_ret");
        step(1,0,0,0,0,1,16'h0000, 16'h0013,0,1,1, "sticky_flags");

        // 5: wrap on inc and on pushed return address
        step(1,1,0,0,0,0,16'h0000, 16'h0000,0,0,0, "clr");
        step(1,0,0,0,1,0,16'hFFFF, 16'hFFFF,0,0,0, "loadFFFF");
        step(1,0,0,0,0,1,16'h0000, 16'h0000,0,0,0, "inc_wrap");
        step(1,0,0,0,1,0,16'hFFFF, 16'hFFFF,0,0,0, "loadFFFF_b");
        step(1,0,1,0,0,0,16'h0020, 16'h0020,1,0,0, "call_wrap");
        step(1,0,0,1,0,0,16'h0000, 16'h0000,0,0,0, "ret_wrap");

        // simultaneous inputs
        step(1,0,1,1,0,0,16'h0030, 16'h0030,1,0,0, "call_beats_ret");
        step(1,0,0,1,1,0,16'h0055, 16'h0001,0,0,0, "ret_beats_load");
        step(1,0,0,1,0,1,16'h0000, 16'h0001,0,0,1, "empty_ret_blocks_inc");
        step(1,1,1,0,0,0,16'h0077, 16'h0000,0,0,0, "clr_beats_call");

        // 6: reset during a call with depth=3, overflow=1
        for (int k = 0; k < DEPTH; k++) begin
            tgt = 16'h2000 + 16'(k);
            step(1,0,1,0,0,0,tgt, tgt,k+1,0,0, "fill2_call");
        end
        step(1,0,1,0,0,0,16'h0abc, 16'h0abc,DEPTH,1,0, "overflow2");
        for (int k = DEPTH - 1; k >= 3; k--) begin
            rv = 16'h2000 + 16'(k - 1) + 16'h0001;
            step(1,0,0,1,0,0,16'h0000, rv,k,1,0, "drain2_ret");
        end
        step(0,0,1,0,0,0,16'h0bad, 16'h0000,0,0,0, "reset_during_call");
        step(1,0,0,1,0,0,16'h0000, 16'h0000,0,0,1, "stack_emptied");
        step(1,0,0,0,0,1,16'h0000, 16'h0001,0,0,1, "inc_after");
        step(1,0,0,0,0,1,16'h0000, 16'h0002,0,0,1, "inc_after2");
        step(1,1,0,0,0,1,16'h0000, 16'h0000,0,0,0, "clr_with_inc");

        @(negedge clock);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
